// File: rtl/mesi_pkg.sv
// Shared MESI encodings and stimulus-entry layout helpers.
// Entry layout, MSB to LSB: {req_id, op, states, exp_bus}.
package mesi_pkg;

  typedef enum logic [2:0] {
    ST_I = 3'b001,
    ST_S = 3'b010,
    ST_M = 3'b011,
    ST_E = 3'b100
  } mesi_state_e;

  typedef enum logic [1:0] {
    OP_RD = 2'b00,
    OP_WR = 2'b01
  } mesi_op_e;

  typedef enum logic [2:0] {
    BUS_NONE = 3'b000,
    BUS_RD   = 3'b001,
    BUS_RDX  = 3'b010,
    BUS_UPGR = 3'b011
  } mesi_bus_e;

  typedef enum logic {
    SEQ_IDLE = 1'b0,
    SEQ_RUN  = 1'b1
  } seq_state_e;

  localparam int ST_W   = 3;
  localparam int OP_W   = 2;
  localparam int BUS_W  = 3;
  localparam int BUS_OFF = 0;
  localparam int ST_OFF  = BUS_W;

  function automatic int rid_w(input int nc);
    return (nc > 1) ? $clog2(nc) : 1;
  endfunction

  function automatic int states_w(input int nc);
    return nc * ST_W;
  endfunction

  function automatic int op_off(input int nc);
    return ST_OFF + states_w(nc);
  endfunction

  function automatic int rid_off(input int nc);
    return op_off(nc) + OP_W;
  endfunction

  function automatic int entry_w(input int nc);
    return rid_off(nc) + rid_w(nc);
  endfunction

endpackage

// File: rtl/mesi_stim_table.sv
// Stimulus table: DEPTH x ENTRY_W register file, one write port, combinational read.
// Contents are deliberately not reset; entries are undefined until written.
module mesi_stim_table
  import mesi_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int ENTRY_W = 12
) (
  input  logic               i_clk,
  input  logic               i_we,
  input  logic [AW-1:0]      i_waddr,
  input  logic [ENTRY_W-1:0] i_wdata,
  input  logic [AW-1:0]      i_raddr,
  output logic [ENTRY_W-1:0] o_rdata
);

  logic [ENTRY_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mesi_stim_sequencer.sv
// Replays a runtime-loaded table of MESI stimulus entries with valid/ready pacing,
// one-shot or looping playback, and abort.
module mesi_stim_sequencer
  import mesi_pkg::*;
#(
  parameter int NUM_CACHES = 2,
  parameter int DEPTH      = 16,
  parameter int AW         = 4,
  localparam int RID_W     = rid_w(NUM_CACHES),
  localparam int STV_W     = states_w(NUM_CACHES),
  localparam int ENTRY_W   = entry_w(NUM_CACHES)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_wr_en,
  input  logic [AW-1:0]      i_wr_addr,
  input  logic [ENTRY_W-1:0] i_wr_data,
  output logic               o_wr_err,
  input  logic               i_start,
  input  logic               i_loop_mode,
  input  logic [AW:0]        i_length,
  input  logic               i_abort,
  input  logic               i_out_ready,
  output logic               o_out_valid,
  output logic [RID_W-1:0]   o_out_req_id,
  output logic [1:0]         o_out_op,
  output logic [STV_W-1:0]   o_out_states,
  output logic [2:0]         o_out_exp_bus,
  output logic               o_busy,
  output logic               o_done
);

  localparam int OP_OFF  = op_off(NUM_CACHES);
  localparam int RID_OFF = rid_off(NUM_CACHES);
  localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LEN_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] IDX_ONE = AW'(1);

  seq_state_e         r_state;
  logic [AW-1:0]      r_idx;
  logic [AW:0]        r_len;
  logic               r_loop;
  logic               r_out_valid;
  logic [ENTRY_W-1:0] r_entry;
  logic               r_done;
  logic               r_wr_err;

  logic               w_busy;
  logic [AW:0]        w_eff_len;
  logic               w_wr_ok;
  logic               w_xfer;
  logic               w_last;
  logic [AW-1:0]      w_rd_addr;
  logic [ENTRY_W-1:0] w_tbl_data;
  logic [ENTRY_W-1:0] w_entry;

  assign w_busy    = (r_state == SEQ_RUN);
  assign w_eff_len = (i_length > DEPTH_L) ? DEPTH_L : i_length;
  assign w_wr_ok   = i_wr_en && !w_busy && ({1'b0, i_wr_addr} < DEPTH_L);
  assign w_xfer    = r_out_valid && i_out_ready;
  assign w_last    = ({1'b0, r_idx} == (r_len - LEN_ONE));
  // Next entry to present: entry 0 when starting or wrapping, otherwise index+1.
  assign w_rd_addr = (w_busy && !w_last) ? (r_idx + IDX_ONE) : '0;

  mesi_stim_table #(
    .DEPTH  (DEPTH),
    .AW     (AW),
    .ENTRY_W(ENTRY_W)
  ) u_table (
    .i_clk  (i_clk),
    .i_we   (w_wr_ok),
    .i_waddr(i_wr_addr),
    .i_wdata(i_wr_data),
    .i_raddr(w_rd_addr),
    .o_rdata(w_tbl_data)
  );

  // A write landing in the same cycle as start must be visible to the first entry.
  assign w_entry = (w_wr_ok && (i_wr_addr == w_rd_addr)) ? i_wr_data : w_tbl_data;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= SEQ_IDLE;
      r_idx       <= '0;
      r_len       <= '0;
      r_loop      <= 1'b0;
      r_out_valid <= 1'b0;
      r_entry     <= '0;
      r_done      <= 1'b0;
      r_wr_err    <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_wr_err <= i_wr_en && !w_wr_ok;
      case (r_state)
        SEQ_IDLE: begin
          if (i_start) begin
            if (w_eff_len == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state     <= SEQ_RUN;
              r_len       <= w_eff_len;
              r_loop      <= i_loop_mode;
              r_idx       <= '0;
              r_out_valid <= 1'b1;
              r_entry     <= w_entry;
            end
          end
        end
        SEQ_RUN: begin
          // Abort takes priority; a coincident transfer still happened on the wire.
          if (i_abort) begin
            r_state     <= SEQ_IDLE;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_entry     <= '0;
            r_done      <= 1'b1;
          end else if (w_xfer) begin
            if (w_last && !r_loop) begin
              r_state     <= SEQ_IDLE;
              r_idx       <= '0;
              r_out_valid <= 1'b0;
              r_entry     <= '0;
              r_done      <= 1'b1;
            end else begin
              r_idx   <= w_rd_addr;
              r_entry <= w_entry;
            end
          end
        end
        default: r_state <= SEQ_IDLE;
      endcase
    end
  end

  assign o_busy        = w_busy;
  assign o_done        = r_done;
  assign o_wr_err      = r_wr_err;
  assign o_out_valid   = r_out_valid;
  assign o_out_exp_bus = r_entry[BUS_OFF +: BUS_W];
  assign o_out_states  = r_entry[ST_OFF +: STV_W];
  assign o_out_op      = r_entry[OP_OFF +: OP_W];
  assign o_out_req_id  = r_entry[RID_OFF +: RID_W];

endmodule

// File: tb/tb_mesi_stim_sequencer.sv
// Self-checking bench for mesi_stim_sequencer: vector table, directed corner cases,
// and randomized playback checked against a table/transfer-count reference model.
module tb_mesi_stim_sequencer;

  localparam int NC  = 2;
  localparam int DEP = 12;
  localparam int AWB = 4;
  localparam int EW  = 12;

  logic          clk, rst;
  logic          wr_en;
  logic [AWB-1:0] wr_addr;
  logic [EW-1:0] wr_data;
  logic          wr_err;
  logic          start, loop_mode, abort, out_ready;
  logic [AWB:0]  length;
  logic          out_valid;
  logic [0:0]    out_req_id;
  logic [1:0]    out_op;
  logic [5:0]    out_states;
  logic [2:0]    out_exp_bus;
  logic          busy, done;
  logic [EW-1:0] out_ent;

  assign out_ent = {out_req_id, out_op, out_states, out_exp_bus};

  mesi_stim_sequencer #(.NUM_CACHES(NC), .DEPTH(DEP), .AW(AWB)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_err(wr_err),
    .i_start(start), .i_loop_mode(loop_mode), .i_length(length), .i_abort(abort),
    .i_out_ready(out_ready), .o_out_valid(out_valid), .o_out_req_id(out_req_id),
    .o_out_op(out_op), .o_out_states(out_states), .o_out_exp_bus(out_exp_bus),
    .o_busy(busy), .o_done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  logic [EW-1:0] model [DEP];

  typedef struct {
    logic          start;
    logic          ready;
    logic          exp_valid;
    logic [EW-1:0] exp_ent;
    logic          exp_done;
    logic          exp_busy;
  } vec_t;
  vec_t vecs [10];

  localparam logic [EW-1:0] E0 = {1'b0, 2'b00, 3'b010, 3'b001, 3'b001};
  localparam logic [EW-1:0] E1 = {1'b0, 2'b01, 3'b010, 3'b001, 3'b010};
  localparam logic [EW-1:0] E2 = {1'b1, 2'b01, 3'b010, 3'b011, 3'b011};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic wr(input int a, input logic [EW-1:0] d, input logic exp_err);
    logic [31:0] av;
    av = a;
    wr_en = 1'b1; wr_addr = av[AWB-1:0]; wr_data = d;
    tick();
    wr_en = 1'b0;
    chk("wr_err", wr_err, exp_err);
    if (!exp_err) model[a] = d;
  endtask

  task automatic start_seq(input int len, input logic lp, input logic rdy);
    logic [31:0] lv;
    lv = len;
    length = lv[AWB:0]; loop_mode = lp; out_ready = rdy; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [EW-1:0] seq3 [3];
    int eff, ntx, cyc, nw, a, len;
    logic lp, rdy, ab, finished, exp_err;

    vecs[0] = '{1'b1, 1'b1, 1'b1, E0, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 1'b1, 1'b1, E1, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b1, E0, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 1'b1, E1, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 1'b1, E1, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 1'b1, E1, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b0};
    vecs[9] = '{1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0};
    seq3[0] = E0; seq3[1] = E1; seq3[2] = E2;

    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
    loop_mode = 1'b0; length = '0; abort = 1'b0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wr_err", wr_err, 0);
    chk("rst_data", out_ent, 0);
    rst = 1'b0;
    tick();

    // Tests 1 and 2: two-entry one-shot, free-running then stalled
    wr(0, E0, 1'b0);
    wr(1, E1, 1'b0);
    length = 5'd2; loop_mode = 1'b0;
    for (int i = 0; i < 10; i++) begin
      start = vecs[i].start; out_ready = vecs[i].ready;
      tick();
      start = 1'b0;
      chk("vec_valid", out_valid, vecs[i].exp_valid);
      chk("vec_done", done, vecs[i].exp_done);
      chk("vec_busy", busy, vecs[i].exp_busy);
      if (vecs[i].exp_valid) chk("vec_data", out_ent, vecs[i].exp_ent);
    end

    // Test 3: loop over three entries, then abort with ready high
    wr(2, E2, 1'b0);
    start_seq(3, 1'b1, 1'b1);
    for (int k = 0; k < 7; k++) begin
      chk("loop_valid", out_valid, 1);
      chk("loop_data", out_ent, seq3[k % 3]);
      chk("loop_nodone", done, 0);
      if (k < 6) tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid", out_valid, 0);
    chk("abort_done", done, 1);
    chk("abort_busy", busy, 0);
    tick();
    chk("abort_done_pulse", done, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("idle_abort_ignored", done, 0);

    // Test 4: rejected writes, readback, and write+start in the same cycle
    start_seq(2, 1'b1, 1'b0);
    wr(0, 12'hFFF, 1'b1);
    chk("busy_wr_stall_data", out_ent, E0);
    start = 1'b1; length = 5'd1;
    tick();
    start = 1'b0;
    chk("busy_start_ignored", out_ent, E0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wr(DEP, 12'h555, 1'b1);
    start_seq(1, 1'b0, 1'b0);
    chk("readback_data", out_ent, E0);
    out_ready = 1'b1;
    tick();
    chk("readback_done", done, 1);
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = E2;
    start_seq(1, 1'b0, 1'b0);
    wr_en = 1'b0;
    model[0] = E2;
    chk("wr_start_bypass", out_ent, E2);
    chk("wr_start_no_err", wr_err, 0);
    out_ready = 1'b1;
    tick();
    chk("wr_start_done", done, 1);

    // Test 5: zero length and over-long length
    start_seq(0, 1'b0, 1'b1);
    chk("len0_valid", out_valid, 0);
    chk("len0_done", done, 1);
    chk("len0_busy", busy, 0);
    tick();
    chk("len0_done_pulse", done, 0);
    for (int i = 0; i < DEP; i++) wr(i, EW'($urandom), 1'b0);
    start_seq(DEP + 5, 1'b0, 1'b1);
    for (int k = 0; k < DEP; k++) begin
      chk("clamp_valid", out_valid, 1);
      chk("clamp_data", out_ent, model[k]);
      tick();
    end
    chk("clamp_end_valid", out_valid, 0);
    chk("clamp_end_done", done, 1);

    // Test 6: asynchronous reset mid-run
    wr(0, E0, 1'b0);
    wr(1, E1, 1'b0);
    start_seq(2, 1'b1, 1'b0);
    chk("prerst_valid", out_valid, 1);
    #3 rst = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_data", out_ent, 0);
    chk("arst_done", done, 0);
    #2 rst = 1'b0;
    tick();
    chk("postrst_done", done, 0);
    start_seq(1, 1'b0, 1'b1);
    chk("restart_data", out_ent, E0);
    tick();
    chk("restart_done", done, 1);

    // Randomized playback: expected entry = table[transfers mod eff_len]
    for (int it = 0; it < 40; it++) begin
      out_ready = 1'b0;
      nw = $urandom_range(0, 4);
      for (int w = 0; w < nw; w++) begin
        a = $urandom_range(0, 15);
        exp_err = (a >= DEP);
        wr(a, EW'($urandom), exp_err);
      end
      len = $urandom_range(0, DEP + 5);
      lp = 1'($urandom_range(0, 1));
      eff = (len > DEP) ? DEP : len;
      start_seq(len, lp, 1'($urandom_range(0, 1)));
      if (eff == 0) begin
        chk("rnd_len0_done", done, 1);
        chk("rnd_len0_valid", out_valid, 0);
        tick();
        continue;
      end
      ntx = 0; finished = 1'b0; cyc = 0;
      while (!finished && cyc < 300) begin
        chk("rnd_valid", out_valid, 1);
        chk("rnd_data", out_ent, model[ntx % eff]);
        rdy = ($urandom_range(0, 3) != 0);
        ab = lp ? (ntx >= eff + 2 && $urandom_range(0, 2) == 0)
                : ($urandom_range(0, 39) == 0);
        out_ready = rdy; abort = ab;
        tick();
        abort = 1'b0;
        cyc++;
        if (ab) begin
          chk("rnd_abort_done", done, 1);
          chk("rnd_abort_valid", out_valid, 0);
          finished = 1'b1;
        end else begin
          if (rdy) ntx++;
          if (rdy && !lp && ntx == eff) begin
            chk("rnd_end_done", done, 1);
            chk("rnd_end_valid", out_valid, 0);
            chk("rnd_end_busy", busy, 0);
            finished = 1'b1;
          end else begin
            chk("rnd_nodone", done, 0);
          end
        end
      end
      if (!finished) begin
        chk("rnd_timeout", 0, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
      end
      out_ready = 1'b0;
      tick();
      chk("rnd_done_pulse", done, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
